axil_ar_slice: RTL and testbench
================================

Name: axil_ar_slice

Overview:
- Parametrised AXI4-Lite read-address channel register slice with a 2-entry skid buffer, carrying ARADDR and ARPROT.
- Includes an outstanding-read limiter: new read addresses are refused once MAX_OUTSTANDING reads are in flight, counted until their R handshakes complete.
- Sits between an AXI4-Lite read master and the interconnect/slave port.
- Replaces the fixed 32-bit master/slave AR pair, adding full throughput, proper VALID/READY hold rules, ARPROT transport and flow limiting.

Parameters:
- ADDR_WIDTH, 32, width of ARADDR (8..64)
- MAX_OUTSTANDING, 4, maximum reads accepted but not yet completed on R (1..255)
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived; do not override)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- s_arvalid  in  1  upstream address valid
- s_arready  out  1  upstream address ready (registered)
- s_araddr  in  ADDR_WIDTH  upstream address
- s_arprot  in  3  upstream protection bits
- m_arvalid  out  1  downstream address valid (registered)
- m_arready  in  1  downstream address ready
- m_araddr  out  ADDR_WIDTH  downstream address (registered)
- m_arprot  out  3  downstream protection (registered)
- m_rvalid  in  1  monitored R-channel valid
- m_rready  in  1  monitored R-channel ready
- outstanding  out  CNT_WIDTH  reads accepted on s side and not yet completed on R
- limit_hit  out  1  high when outstanding == MAX_OUTSTANDING
- err_underflow  out  1  sticky: R handshake seen with outstanding == 0

Behaviour:
- Handshake definitions:
  - s_hs = s_arvalid & s_arready
  - m_hs = m_arvalid & m_arready
  - r_hs = m_rvalid & m_rready
- Reset (ARESETn=0 at a clock edge):
  - Outputs: m_arvalid=0, s_arready=0, m_araddr=0, m_arprot=0, outstanding=0, limit_hit=0, err_underflow=0.
  - Skid entry is cleared.
  - Reset mid-operation drops all buffered and in-flight state; no request is replayed.
- s_arready rises on the first edge after ARESETn deasserts.
- State machine over (main valid, skid valid):
  - EMPTY: s_hs -> ONE, main loaded with s payload.
  - ONE:
    - s_hs & m_hs -> ONE, main reloaded.
    - s_hs & !m_hs -> TWO, skid loaded.
    - !s_hs & m_hs -> EMPTY.
    - otherwise hold.
  - TWO: m_hs -> ONE, main <= skid; otherwise hold. s_hs cannot occur in TWO.
- m_arvalid = (state != EMPTY).
- m_araddr/m_arprot must stay stable while m_arvalid & !m_arready (AXI hold rule); the payload changes only on m_hs or on a load into an empty main register.
- Latency: s_hs at edge N -> m_arvalid high after edge N (visible cycle N+1).
- Throughput: one transfer per cycle when m_arready=1 and the limit is not reached.
- s_arready (registered) next value = (next state != TWO) & (next outstanding < MAX_OUTSTANDING).
  - It never depends combinationally on s_arvalid.
  - Once asserted, it stays high until a handshake occurs or the limit is reached.
- Outstanding counter:
  - +1 on s_hs, -1 on r_hs; simultaneous s_hs and r_hs leave it unchanged.
  - r_hs with outstanding==0: counter stays 0 and err_underflow sets until reset.
  - Counter never exceeds MAX_OUTSTANDING (guaranteed by s_arready gating).
- limit_hit is registered and tracks outstanding == MAX_OUTSTANDING in the same cycle.
- R data itself is not buffered or modified; the block only monitors the R handshake.

Decomposition:
- Package axil_pkg:
  - AXIL_PROT_W = 3
  - ar_payload_t struct {addr, prot}, with addr sized by ADDR_WIDTH via a parameterised typedef or flattened vector
  - slice_state_t enum {EMPTY, ONE, TWO}
- Sub-module axil_skid_buffer (generic DATA_WIDTH; valid/ready/data in and out, plus an external accept-enable input) implements the 2-entry buffer.
- axil_ar_slice instantiates it and adds the outstanding counter, limiter and error flag.

Test Plan:
- Reset, then m_arready=1, s_arvalid=1 for 4 cycles with addr 0x100,0x104,0x108,0x10C and prot=3'b010 -> m_araddr shows the same sequence one cycle later, prot carried; outstanding=4; limit_hit=1; s_arready=0 after the 4th accept.
- With MAX_OUTSTANDING=4 held at the limit, pulse one r_hs -> outstanding=3, limit_hit=0, s_arready=1 next cycle; next address 0x200 accepted.
- m_arready=0, two uploads 0xA0, 0xB0 -> state TWO, s_arready=0, m_araddr holds 0xA0 stable; raise m_arready -> 0xA0 then 0xB0 issued on consecutive cycles.
- Same cycle s_hs and r_hs with outstanding=2 -> outstanding stays 2.
- r_hs with outstanding=0 -> outstanding stays 0, err_underflow=1 and remains 1 until ARESETn=0.
- Assert ARESETn=0 while in TWO with outstanding=3 -> next cycle m_arvalid=0, outstanding=0, s_arready=0; s_arready=1 one cycle after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite slice definitions: protection width and the 2-entry buffer occupancy states.
package axil_pkg;

    localparam int unsigned AXIL_PROT_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slice_state_t;

endpackage

// File: rtl/axil_skid_buffer.sv
// Full-throughput 2-entry register slice with a registered upstream ready.
// i_accept_en lets the parent block new uploads without touching the downstream side.
module axil_skid_buffer
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_accept_en
);

    slice_state_t          r_state;
    slice_state_t          w_state_d;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_ready;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid;

    assign w_in_hs  = i_valid & r_ready;
    assign w_out_hs = o_valid & i_ready;
    assign o_valid  = (r_state != EMPTY);
    assign o_ready  = r_ready;
    assign o_data   = r_main;

    always_comb begin
        w_state_d        = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_in_hs) begin
                    w_state_d      = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_hs) begin
                    w_state_d   = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_hs) begin
                    w_state_d = EMPTY;
                end
            end
            TWO: begin
                // r_ready is low here, so no upload can arrive alongside the drain
                if (w_out_hs) begin
                    w_state_d        = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ready <= (w_state_d != TWO) && i_accept_en;
            if (w_load_main_in) begin
                r_main <= i_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/axil_ar_slice.sv
// AXI4-Lite read-address register slice carrying ARADDR/ARPROT, with an outstanding-read
// limiter driven by the monitored R handshake.
module axil_ar_slice
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    input  logic [ADDR_WIDTH-1:0]  s_araddr,
    input  logic [AXIL_PROT_W-1:0] s_arprot,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [ADDR_WIDTH-1:0]  m_araddr,
    output logic [AXIL_PROT_W-1:0] m_arprot,
    input  logic                   m_rvalid,
    input  logic                   m_rready,
    output logic [CNT_WIDTH-1:0]   outstanding,
    output logic                   limit_hit,
    output logic                   err_underflow
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [AXIL_PROT_W-1:0] prot;
    } ar_payload_t;

    localparam int unsigned          PL_W    = $bits(ar_payload_t);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    ar_payload_t          w_s_pl;
    ar_payload_t          w_m_pl;
    logic                 w_s_hs;
    logic                 w_r_hs;
    logic                 w_accept_en;
    logic [CNT_WIDTH-1:0] w_cnt_d;
    logic                 w_err_d;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_limit;
    logic                 r_err;

    assign w_s_pl        = {s_araddr, s_arprot};
    assign m_araddr      = w_m_pl.addr;
    assign m_arprot      = w_m_pl.prot;
    assign w_s_hs        = s_arvalid & s_arready;
    assign w_r_hs        = m_rvalid & m_rready;
    assign outstanding   = r_cnt;
    assign limit_hit     = r_limit;
    assign err_underflow = r_err;

    axil_skid_buffer #(
        .DATA_WIDTH (PL_W)
    ) u_skid (
        .i_clk       (ACLK),
        .i_rst_n     (ARESETn),
        .i_valid     (s_arvalid),
        .o_ready     (s_arready),
        .i_data      (w_s_pl),
        .o_valid     (m_arvalid),
        .i_ready     (m_arready),
        .o_data      (w_m_pl),
        .i_accept_en (w_accept_en)
    );

    always_comb begin
        w_cnt_d = r_cnt;
        w_err_d = r_err;
        if (w_r_hs && (r_cnt == '0)) begin
            w_err_d = 1'b1;
        end
        // A completion with nothing in flight is flagged, never allowed to wrap the counter
        if (w_s_hs && !w_r_hs) begin
            w_cnt_d = r_cnt + 1'b1;
        end else if (!w_s_hs && w_r_hs && (r_cnt != '0)) begin
            w_cnt_d = r_cnt - 1'b1;
        end
        w_accept_en = (w_cnt_d < MAX_CNT);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_cnt   <= '0;
            r_limit <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_limit <= (w_cnt_d == MAX_CNT);
            r_err   <= w_err_d;
        end
    end

endmodule

// File: tb/tb_axil_ar_slice.sv
// Directed bench for axil_ar_slice (ADDR_WIDTH=32, MAX_OUTSTANDING=4).
module tb_axil_ar_slice;

    logic        ACLK;
    logic        ARESETn;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_rvalid;
    logic        m_rready;
    logic [2:0]  outstanding;
    logic        limit_hit;
    logic        err_underflow;

    int vectors;
    int miscompares;

    axil_ar_slice #(
        .ADDR_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .s_araddr      (s_araddr),
        .s_arprot      (s_arprot),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_araddr      (m_araddr),
        .m_arprot      (m_arprot),
        .m_rvalid      (m_rvalid),
        .m_rready      (m_rready),
        .outstanding   (outstanding),
        .limit_hit     (limit_hit),
        .err_underflow (err_underflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Advance one edge; outputs are then sampled and inputs re-driven 1 time unit later.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rready = 1'b0;
        tick(); tick();
        vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_arvalid got %b want 0", m_arvalid); end
        vectors++; if (s_arready !== 1'b0) begin miscompares++; $display("FAIL reset_s_arready got %b want 0", s_arready); end
        vectors++; if (m_araddr !== 32'h0) begin miscompares++; $display("FAIL reset_m_araddr got %h want 0", m_araddr); end
        vectors++; if (m_arprot !== 3'b000) begin miscompares++; $display("FAIL reset_m_arprot got %b want 000", m_arprot); end
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        vectors++; if (limit_hit !== 1'b0) begin miscompares++; $display("FAIL reset_limit_hit got %b want 0", limit_hit); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_underflow); end
        ARESETn = 1'b1;
        tick();
        vectors++; if (s_arready !== 1'b1) begin miscompares++; $display("FAIL release_s_arready got %b want 1", s_arready); end
    endtask

    task automatic test_burst_to_limit();
        logic [31:0] exp_addr;
        m_arready = 1'b1; s_arvalid = 1'b1; s_arprot = 3'b010;
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'h100 + 32'(4 * i);
            s_araddr = exp_addr;
            tick();
            vectors++; if (m_arvalid !== 1'b1 || m_araddr !== exp_addr) begin miscompares++; $display("FAIL burst_addr[%0d] got v=%b %h want v=1 %h", i, m_arvalid, m_araddr, exp_addr); end
            vectors++; if (m_arprot !== 3'b010) begin miscompares++; $display("FAIL burst_prot[%0d] got %b want 010", i, m_arprot); end
        end
        vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL burst_outstanding got %0d want 4", outstanding); end
        vectors++; if (limit_hit !== 1'b1) begin miscompares++; $display("FAIL burst_limit_hit got %b want 1", limit_hit); end
        vectors++; if (s_arready !== 1'b0) begin miscompares++; $display("FAIL burst_s_arready got %b want 0", s_arready); end
        s_arvalid = 1'b0;
        tick();
        vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL burst_drain_valid got %b want 0", m_arvalid); end
        vectors++; if (s_arready !== 1'b0 || outstanding !== 3'd4) begin miscompares++; $display("FAIL burst_held_at_limit got rdy=%b cnt=%0d want rdy=0 cnt=4", s_arready, outstanding); end
    endtask

    task automatic test_limit_release();
        m_rvalid = 1'b1; m_rready = 1'b1;
        tick();
        m_rvalid = 1'b0;
        vectors++; if (outstanding !== 3'd3) begin miscompares++; $display("FAIL release_outstanding got %0d want 3", outstanding); end
        vectors++; if (limit_hit !== 1'b0) begin miscompares++; $display("FAIL release_limit_hit got %b want 0", limit_hit); end
        vectors++; if (s_arready !== 1'b1) begin miscompares++; $display("FAIL release_ready got %b want 1", s_arready); end
        s_arvalid = 1'b1; s_araddr = 32'h200; s_arprot = 3'b101;
        tick();
        s_arvalid = 1'b0;
        vectors++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h200 || m_arprot !== 3'b101) begin miscompares++; $display("FAIL release_accept got v=%b %h %b want v=1 00000200 101", m_arvalid, m_araddr, m_arprot); end
        vectors++; if (outstanding !== 3'd4 || limit_hit !== 1'b1 || s_arready !== 1'b0) begin miscompares++; $display("FAIL release_relimit got cnt=%0d lim=%b rdy=%b want 4 1 0", outstanding, limit_hit, s_arready); end
        tick();
        m_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        m_rvalid = 1'b0;
        vectors++; if (outstanding !== 3'd0 || err_underflow !== 1'b0) begin miscompares++; $display("FAIL release_drain got cnt=%0d err=%b want 0 0", outstanding, err_underflow); end
    endtask

    task automatic test_back_to_back_stall();
        m_arready = 1'b0;
        s_arvalid = 1'b1; s_araddr = 32'hA0; s_arprot = 3'b001;
        tick();
        s_araddr = 32'hB0;
        tick();
        s_araddr = 32'hC0;
        vectors++; if (s_arready !== 1'b0) begin miscompares++; $display("FAIL stall_ready got %b want 0", s_arready); end
        vectors++; if (m_araddr !== 32'hA0 || m_arvalid !== 1'b1) begin miscompares++; $display("FAIL stall_addr got v=%b %h want v=1 000000a0", m_arvalid, m_araddr); end
        tick();
        vectors++; if (m_araddr !== 32'hA0 || outstanding !== 3'd2) begin miscompares++; $display("FAIL stall_hold got %h cnt=%0d want 000000a0 cnt=2", m_araddr, outstanding); end
        s_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        vectors++; if (m_arvalid !== 1'b1 || m_araddr !== 32'hB0) begin miscompares++; $display("FAIL stall_second got v=%b %h want v=1 000000b0", m_arvalid, m_araddr); end
        vectors++; if (s_arready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_back got %b want 1", s_arready); end
        tick();
        vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL stall_empty got %b want 0", m_arvalid); end
    endtask

    task automatic test_simultaneous();
        s_arvalid = 1'b1; s_araddr = 32'h300; s_arprot = 3'b000;
        m_rvalid = 1'b1; m_rready = 1'b1;
        tick();
        s_arvalid = 1'b0; m_rvalid = 1'b0;
        vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL simul_outstanding got %0d want 2", outstanding); end
        vectors++; if (m_araddr !== 32'h300) begin miscompares++; $display("FAIL simul_addr got %h want 00000300", m_araddr); end
        tick();
        m_rvalid = 1'b1;
        tick(); tick();
        m_rvalid = 1'b0;
        vectors++; if (outstanding !== 3'd0 || err_underflow !== 1'b0) begin miscompares++; $display("FAIL simul_drain got cnt=%0d err=%b want 0 0", outstanding, err_underflow); end
    endtask

    task automatic test_underflow();
        m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL underflow_cnt got %0d want 0", outstanding); end
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_err got %b want 1", err_underflow); end
        tick(); tick();
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %b want 1", err_underflow); end
    endtask

    task automatic test_reset_mid();
        m_arready = 1'b1; s_arvalid = 1'b1; s_arprot = 3'b011;
        s_araddr = 32'h3F0;
        tick();
        s_araddr = 32'h3F4;
        tick();
        m_arready = 1'b0; s_araddr = 32'h400;
        tick();
        s_arvalid = 1'b0;
        vectors++; if (outstanding !== 3'd3 || s_arready !== 1'b0 || m_araddr !== 32'h3F4) begin miscompares++; $display("FAIL mid_setup got cnt=%0d rdy=%b %h want 3 0 000003f4", outstanding, s_arready, m_araddr); end
        ARESETn = 1'b0;
        tick();
        vectors++; if (m_arvalid !== 1'b0 || outstanding !== 3'd0 || s_arready !== 1'b0) begin miscompares++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b want 0 0 0", m_arvalid, outstanding, s_arready); end
        vectors++; if (err_underflow !== 1'b0 || limit_hit !== 1'b0 || m_araddr !== 32'h0) begin miscompares++; $display("FAIL mid_reset_clear got err=%b lim=%b %h want 0 0 0", err_underflow, limit_hit, m_araddr); end
        ARESETn = 1'b1;
        tick();
        vectors++; if (s_arready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready got %b want 1", s_arready); end
        tick();
        vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL mid_no_replay got %b want 0", m_arvalid); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_burst_to_limit();
        test_limit_release();
        test_back_to_back_stall();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
